// File: rtl/sequential_multiplier_if.sv
// Start/done handshake and result bus of the iterative multiplier.
// The requester drives the operands; the multiplier returns the result and status.
interface sequential_multiplier_if #(parameter int WIDTH = 8);
  logic               START;
  logic               SIGNED;
  logic [WIDTH-1:0]   IN1;
  logic [WIDTH-1:0]   IN2;
  logic [2*WIDTH-1:0] PRODUCT;
  logic [WIDTH-1:0]   OUT;
  logic               OVERFLOW;
  logic               BUSY;
  logic               DONE;

  modport master (
    output START, SIGNED, IN1, IN2,
    input  PRODUCT, OUT, OVERFLOW, BUSY, DONE
  );

  modport slave (
    input  START, SIGNED, IN1, IN2,
    output PRODUCT, OUT, OVERFLOW, BUSY, DONE
  );
endinterface

// File: rtl/sequential_multiplier.sv
// Iterative shift-add multiplier: one WIDTH+1-bit adder, WIDTH+1 cycles per
// result, unsigned or two's-complement operands via sign-magnitude.
module sequential_multiplier #(
  parameter int WIDTH = 8
) (
  input logic                   CLK,
  input logic                   RESET,
  sequential_multiplier_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;
  logic               neg_q;
  logic               signed_q;
  logic [2*WIDTH-1:0] product_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] full;
  logic [2*WIDTH-1:0] product_d;
  logic               ovf_d;
  logic [WIDTH-1:0]   in1_abs;
  logic [WIDTH-1:0]   in2_abs;

  // The last step's sum feeds the product directly, so the result registers
  // on the same edge that performs the final add-and-shift.
  always_comb begin
    addend    = mplier_q[0] ? {1'b0, mcand_q} : '0;
    sum       = {1'b0, acc_q} + addend;
    full      = {sum, mplier_q[WIDTH-1:1]};
    product_d = neg_q ? -full : full;
    if (signed_q)
      ovf_d = (product_d[2*WIDTH-1:WIDTH] != {WIDTH{product_d[WIDTH-1]}});
    else
      ovf_d = (product_d[2*WIDTH-1:WIDTH] != '0);
    in1_abs = (bus.SIGNED && bus.IN1[WIDTH-1]) ? -bus.IN1 : bus.IN1;
    in2_abs = (bus.SIGNED && bus.IN2[WIDTH-1]) ? -bus.IN2 : bus.IN2;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      signed_q  <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.START) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            mcand_q  <= in1_abs;
            mplier_q <= in2_abs;
            acc_q    <= '0;
            count_q  <= '0;
            neg_q    <= bus.SIGNED & (bus.IN1[WIDTH-1] ^ bus.IN2[WIDTH-1]);
            signed_q <= bus.SIGNED;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q    <= sum[WIDTH:1];
          mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
          count_q  <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= product_d;
            ovf_q     <= ovf_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.PRODUCT  = product_q;
  assign bus.OUT      = product_q[WIDTH-1:0];
  assign bus.OVERFLOW = ovf_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
endmodule
